// File: rtl/mcu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mcu_sequencer
// Purpose  : Main-control sequencer. Runs the digit/minor-cycle timing chain
//            and steps the order cycle: fetch, stimulate CCUs, wait for an
//            end pulse, acknowledge, advance the sequence control tank.
// Revision : 1.0 - initial release
// ============================================================================
module mcu_sequencer #(
    parameter int DIGITS     = 36,
    parameter int NUM_CCU    = 12,
    parameter int TIMEOUT_MC = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    output logic               fetch_req,
    input  logic               fetch_done,
    output logic               s2,
    input  logic [NUM_CCU-1:0] ep,
    output logic               ep_done,
    input  logic               stop_one_b,
    input  logic               stop_order,
    output logic               sct_inc,
    output logic               ev_d0,
    output logic               odd_d0,
    output logic               odd_d35,
    output logic               halted,
    output logic               fault
);

    localparam int c_digit_w = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_tmo_w   = $clog2(TIMEOUT_MC + 1);
    localparam logic [c_digit_w-1:0] c_digit_last = c_digit_w'(DIGITS - 1);
    localparam logic [c_tmo_w-1:0]   c_tmo_last   = c_tmo_w'(TIMEOUT_MC - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT_F  = 3'd2,
        ST_EXEC    = 3'd3,
        ST_WAIT_EP = 3'd4,
        ST_EP_DONE = 3'd5,
        ST_ADV     = 3'd6,
        ST_HALT    = 3'd7
    } state_t;

    logic [c_digit_w-1:0] r_digit;
    logic                 r_odd;
    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_stop_latch;
    logic                 w_stop_latch_nxt;
    logic [c_tmo_w-1:0]   r_tmo_cnt;
    logic [c_tmo_w-1:0]   w_tmo_cnt_nxt;
    logic                 r_fault;
    logic                 w_fault_nxt;
    logic                 r_run_d;
    logic                 w_wrap;
    logic                 w_d0_even;

    // Free-running digit counter; the odd/even minor-cycle flag flips on each wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_digit <= '0;
            r_odd   <= 1'b0;
        end else if (r_digit == c_digit_last) begin
            r_digit <= '0;
            r_odd   <= ~r_odd;
        end else begin
            r_digit <= r_digit + c_digit_w'(1);
        end
    end

    assign w_wrap    = (r_digit == c_digit_last);
    assign w_d0_even = !r_odd && (r_digit == '0);

    // Timing pulses are masked while reset is held so nothing pulses in the reset cycle.
    assign ev_d0   = !rst && w_d0_even;
    assign odd_d0  = !rst && r_odd && (r_digit == '0);
    assign odd_d35 = !rst && r_odd && w_wrap;
    assign fault   = r_fault;

    // Order-cycle state and its bookkeeping (transfer latch, timeout count, sticky fault).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_stop_latch <= 1'b0;
            r_tmo_cnt    <= '0;
            r_fault      <= 1'b0;
            r_run_d      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_stop_latch <= w_stop_latch_nxt;
            r_tmo_cnt    <= w_tmo_cnt_nxt;
            r_fault      <= w_fault_nxt;
            r_run_d      <= run;
        end
    end

    // Next-state and pulse outputs for the order cycle.
    always_comb begin
        w_state_nxt      = r_state;
        w_stop_latch_nxt = r_stop_latch;
        w_tmo_cnt_nxt    = r_tmo_cnt;
        w_fault_nxt      = r_fault;
        fetch_req        = 1'b0;
        s2               = 1'b0;
        ep_done          = 1'b0;
        sct_inc          = 1'b0;
        halted           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (run) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (w_d0_even) begin
                    fetch_req        = 1'b1;
                    // A new order starts with no pending transfer from the last one.
                    w_stop_latch_nxt = 1'b0;
                    w_state_nxt      = ST_WAIT_F;
                end
            end
            ST_WAIT_F: begin
                if (fetch_done) w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                if (stop_order) begin
                    w_state_nxt = ST_HALT;
                end else if (w_d0_even) begin
                    s2               = 1'b1;
                    w_stop_latch_nxt = 1'b0;
                    w_tmo_cnt_nxt    = '0;
                    w_state_nxt      = ST_WAIT_EP;
                end
            end
            ST_WAIT_EP: begin
                if (stop_one_b) w_stop_latch_nxt = 1'b1;
                // An end pulse takes priority over a timeout landing in the same cycle.
                if (|ep) begin
                    w_state_nxt = ST_EP_DONE;
                end else if (w_wrap) begin
                    if (r_tmo_cnt == c_tmo_last) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_tmo_cnt_nxt = r_tmo_cnt + c_tmo_w'(1);
                    end
                end
            end
            ST_EP_DONE: begin
                ep_done = 1'b1;
                if (stop_one_b) w_stop_latch_nxt = 1'b1;
                w_state_nxt = ST_ADV;
            end
            ST_ADV: begin
                sct_inc     = !(r_stop_latch || stop_one_b);
                w_state_nxt = run ? ST_FETCH : ST_IDLE;
            end
            ST_HALT: begin
                halted = 1'b1;
                // Only a fresh run request steps past the stopping order.
                if (run && !r_run_d) w_state_nxt = ST_ADV;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
